// File: rtl/micro_dbg_pkg.sv
// Shared types for the micro-core debug controls: execution states and request arbitration.
// Latency: none (types, constants and a pure function).
// Backpressure: none; requests are single-cycle ticks that are either taken or dropped.
package micro_dbg_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_HALT  = 3'd0,
        ST_STEP  = 3'd1,
        ST_NSTEP = 3'd2,
        ST_RUN   = 3'd3,
        ST_SRST  = 3'd4
    } exec_state_t;

    typedef enum logic [2:0] {
        REQ_NONE,
        REQ_SRST,
        REQ_HALT,
        REQ_STEP,
        REQ_NSTEP,
        REQ_RUN
    } exec_req_t;

    // Priority when several ticks coincide: srst > halt > step > nstep > run.
    function automatic exec_req_t pick_req(input logic srst, input logic halt,
                                           input logic step, input logic nstep,
                                           input logic run);
        exec_req_t r;
        r = REQ_NONE;
        if (run)   r = REQ_RUN;
        if (nstep) r = REQ_NSTEP;
        if (step)  r = REQ_STEP;
        if (halt)  r = REQ_HALT;
        if (srst)  r = REQ_SRST;
        return r;
    endfunction

endpackage

// File: rtl/micro_exec_ctl_rate_div.sv
// Loadable period counter: counts 0..period-1 while enabled and flags the last count.
// Latency: tick is a decode of the counter register; a load takes effect on the next cycle.
// Backpressure: none; en simply freezes the count.
module micro_exec_ctl_rate_div #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [DIV_W-1:0] period_in,
    output logic             tick
);

    logic [DIV_W-1:0] period_q, period_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == period_q - DIV_W'(1));

    // Load clamps a zero period to 1 so the wrap compare is always reachable.
    always_comb begin
        period_d = period_q;
        cnt_d    = cnt_q;
        if (load) begin
            period_d = (period_in == '0) ? DIV_W'(1) : period_in;
            cnt_d    = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
        end
    end

    // Period and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q <= DIV_W'(1);
            cnt_q    <= '0;
        end else begin
            period_q <= period_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/micro_exec_ctl.sv
// Execution controller for the micro core: halt / single-step / N-step / paced run, PC breakpoint, soft reset.
// Latency: tick to first pc_en is 1 cycle (RUN: period cycles after entry); all outputs decode registers.
// Backpressure: none; ticks not accepted in the current state are dropped.
module micro_exec_ctl
    import micro_dbg_pkg::*;
#(
    parameter int PC_W    = 16,
    parameter int CNT_W   = 16,
    parameter int DIV_W   = 24,
    parameter int RST_CYC = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               step_tick,
    input  logic               run_tick,
    input  logic               nstep_tick,
    input  logic               halt_tick,
    input  logic               srst_tick,
    input  logic [CNT_W-1:0]   nstep_cnt,
    input  logic [DIV_W-1:0]   run_div,
    input  logic               bp_en,
    input  logic [PC_W-1:0]    bp_addr,
    input  logic [PC_W-1:0]    core_pc,
    output logic               pc_en,
    output logic               core_rst,
    output logic               halted,
    output logic               bp_hit,
    output logic [CNT_W-1:0]   steps_left,
    output logic [STATE_W-1:0] state_o
);

    localparam int RC_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    exec_state_t      state_q, state_d;
    logic [CNT_W-1:0] steps_left_q, steps_left_d;
    logic             bp_hit_q, bp_hit_d;
    logic             bp_arm_q, bp_arm_d;   // set once the mode has issued a pulse
    logic             phase_q, phase_d;     // NSTEP: 0 = pulse cycle, 1 = gap cycle
    logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;

    exec_req_t        req;
    logic             pc_en_w;
    logic             bp_trip;
    logic             div_tick;
    logic             div_load;

    micro_exec_ctl_rate_div #(.DIV_W(DIV_W)) u_rate_div (
        .clk       (clk),
        .rst_n     (rst),
        .load      (div_load),
        .en        (state_q == ST_RUN),
        .period_in (run_div),
        .tick      (div_tick)
    );

    // A zero-length N-step request is treated as no request at all.
    assign req = pick_req(srst_tick, halt_tick, step_tick,
                          nstep_tick && (nstep_cnt != '0), run_tick);

    assign pc_en_w = (state_q == ST_STEP)
                   || ((state_q == ST_NSTEP) && !phase_q)
                   || ((state_q == ST_RUN) && div_tick);

    // Compare only in non-pulse cycles so core_pc has settled, and only after
    // the first pulse so execution can resume from a PC sitting on the breakpoint.
    assign bp_trip = bp_en && (core_pc == bp_addr) && !pc_en_w && bp_arm_q
                   && ((state_q == ST_NSTEP) || (state_q == ST_RUN));

    assign pc_en      = pc_en_w;
    assign core_rst   = (state_q == ST_SRST);
    assign halted     = (state_q == ST_HALT);
    assign bp_hit     = bp_hit_q;
    assign steps_left = steps_left_q;
    assign state_o    = state_q;

    // Next-state and counter updates.
    always_comb begin
        state_d      = state_q;
        steps_left_d = steps_left_q;
        bp_hit_d     = bp_hit_q;
        bp_arm_d     = bp_arm_q || pc_en_w;
        phase_d      = phase_q;
        rst_cnt_d    = rst_cnt_q;
        div_load     = 1'b0;

        if (req == REQ_SRST) begin
            state_d      = ST_SRST;
            rst_cnt_d    = '0;
            steps_left_d = '0;
        end else begin
            case (state_q)
                ST_HALT: begin
                    case (req)
                        REQ_STEP: begin
                            state_d  = ST_STEP;
                            bp_hit_d = 1'b0;
                        end
                        REQ_NSTEP: begin
                            state_d      = ST_NSTEP;
                            steps_left_d = nstep_cnt;
                            phase_d      = 1'b0;
                            bp_arm_d     = 1'b0;
                            bp_hit_d     = 1'b0;
                        end
                        REQ_RUN: begin
                            state_d  = ST_RUN;
                            div_load = 1'b1;
                            bp_arm_d = 1'b0;
                            bp_hit_d = 1'b0;
                        end
                        default: ;
                    endcase
                end
                ST_STEP: begin
                    state_d = ST_HALT;
                end
                ST_NSTEP: begin
                    phase_d = !phase_q;
                    if (pc_en_w && (steps_left_q != '0)) begin
                        steps_left_d = steps_left_q - CNT_W'(1);
                    end
                    if (req == REQ_HALT) begin
                        state_d = ST_HALT;
                    end else if (pc_en_w && (steps_left_q <= CNT_W'(1))) begin
                        state_d = ST_HALT;
                    end else if (bp_trip) begin
                        state_d  = ST_HALT;
                        bp_hit_d = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (req == REQ_HALT) begin
                        state_d = ST_HALT;
                    end else if (bp_trip) begin
                        state_d  = ST_HALT;
                        bp_hit_d = 1'b1;
                    end
                end
                ST_SRST: begin
                    steps_left_d = '0;
                    if (rst_cnt_q == RC_W'(RST_CYC - 1)) begin
                        state_d = ST_HALT;
                    end else begin
                        rst_cnt_d = rst_cnt_q + RC_W'(1);
                    end
                end
                default: begin
                    state_d = ST_HALT;
                end
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_HALT;
            steps_left_q <= '0;
            bp_hit_q     <= 1'b0;
            bp_arm_q     <= 1'b0;
            phase_q      <= 1'b0;
            rst_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            steps_left_q <= steps_left_d;
            bp_hit_q     <= bp_hit_d;
            bp_arm_q     <= bp_arm_d;
            phase_q      <= phase_d;
            rst_cnt_q    <= rst_cnt_d;
        end
    end

endmodule

// File: tb/tb_micro_exec_ctl.sv
// Directed bench for micro_exec_ctl: one-cycle vector table plus multi-cycle sequences.
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_micro_exec_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic        step_tick, run_tick, nstep_tick, halt_tick, srst_tick;
    logic [15:0] nstep_cnt;
    logic [23:0] run_div;
    logic        bp_en;
    logic [15:0] bp_addr;
    logic [15:0] core_pc;
    logic        pc_en, core_rst, halted, bp_hit;
    logic [15:0] steps_left;
    logic [2:0]  state_o;
    logic        pc_clr;

    int n_cmp = 0;
    int n_bad = 0;
    int pulses;
    int n_rst;
    int n_pe;

    always #5 clk = ~clk;

    // Core model: PC advances by one on every pc_en pulse.
    always @(posedge clk) begin
        if (pc_clr) core_pc <= 16'd0;
        else if (pc_en) core_pc <= core_pc + 16'd1;
    end

    micro_exec_ctl dut (
        .clk        (clk),
        .rst        (rst),
        .step_tick  (step_tick),
        .run_tick   (run_tick),
        .nstep_tick (nstep_tick),
        .halt_tick  (halt_tick),
        .srst_tick  (srst_tick),
        .nstep_cnt  (nstep_cnt),
        .run_div    (run_div),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .core_pc    (core_pc),
        .pc_en      (pc_en),
        .core_rst   (core_rst),
        .halted     (halted),
        .bp_hit     (bp_hit),
        .steps_left (steps_left),
        .state_o    (state_o)
    );

    typedef struct {
        logic        st, rn, ns, ht, sr;
        logic [15:0] cnt;
        logic [23:0] dv;
        logic        pe, cr, hd;
        logic [2:0]  so;
        logic [15:0] sl;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic st, input logic rn, input logic ns,
                               input logic ht, input logic sr,
                               input logic [15:0] cnt, input logic [23:0] dv,
                               input logic pe, input logic cr, input logic hd,
                               input logic [2:0] so, input logic [15:0] sl);
        vec_t r;
        r.st = st; r.rn = rn; r.ns = ns; r.ht = ht; r.sr = sr;
        r.cnt = cnt; r.dv = dv;
        r.pe = pe; r.cr = cr; r.hd = hd; r.so = so; r.sl = sl;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic go();
        @(negedge clk);
        step_tick  = 1'b0;
        run_tick   = 1'b0;
        nstep_tick = 1'b0;
        halt_tick  = 1'b0;
        srst_tick  = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit hit before summary, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //         st rn ns ht sr cnt dv   pe cr hd so sl
        tbl.push_back(v(0,0,0,0,0, 0,0, 0,0,1,0,0));  // idle in HALT
        tbl.push_back(v(1,0,0,0,0, 0,0, 1,0,0,1,0));  // step -> one pulse
        tbl.push_back(v(0,0,0,0,0, 0,0, 0,0,1,0,0));
        tbl.push_back(v(0,0,1,0,0, 0,0, 0,0,1,0,0));  // nstep with count 0 ignored
        tbl.push_back(v(0,0,1,0,0, 5,0, 1,0,0,2,5));  // nstep 5
        tbl.push_back(v(0,0,0,0,0, 0,0, 0,0,0,2,4));
        tbl.push_back(v(0,0,0,0,0, 0,0, 1,0,0,2,4));
        tbl.push_back(v(0,0,0,0,0, 0,0, 0,0,0,2,3));
        tbl.push_back(v(0,0,0,0,0, 0,0, 1,0,0,2,3));
        tbl.push_back(v(0,0,0,0,0, 0,0, 0,0,0,2,2));
        tbl.push_back(v(0,0,0,0,0, 0,0, 1,0,0,2,2));
        tbl.push_back(v(0,0,0,0,0, 0,0, 0,0,0,2,1));
        tbl.push_back(v(0,0,0,0,0, 0,0, 1,0,0,2,1));
        tbl.push_back(v(0,0,0,0,0, 0,0, 0,0,1,0,0));  // back to HALT after 5th pulse
        tbl.push_back(v(0,0,0,0,0, 0,0, 0,0,1,0,0));
        tbl.push_back(v(0,1,0,0,0, 0,4, 0,0,0,3,0));  // run, period 4
        tbl.push_back(v(0,0,0,0,0, 0,0, 0,0,0,3,0));  // run_div change ignored while running
        tbl.push_back(v(0,0,0,0,0, 0,0, 0,0,0,3,0));
        tbl.push_back(v(0,0,0,0,0, 0,0, 1,0,0,3,0));
        tbl.push_back(v(0,0,0,0,0, 0,0, 0,0,0,3,0));
        tbl.push_back(v(0,0,0,0,0, 0,0, 0,0,0,3,0));
        tbl.push_back(v(0,0,0,0,0, 0,0, 0,0,0,3,0));
        tbl.push_back(v(0,0,0,0,0, 0,0, 1,0,0,3,0));
        tbl.push_back(v(1,0,0,1,0, 0,0, 0,0,1,0,0));  // halt+step in RUN: halt wins
        tbl.push_back(v(0,0,0,0,0, 0,0, 0,0,1,0,0));
        tbl.push_back(v(0,1,0,0,0, 0,0, 1,0,0,3,0));  // run_div 0 -> every cycle
        tbl.push_back(v(0,0,0,0,0, 0,0, 1,0,0,3,0));
        tbl.push_back(v(0,0,0,0,0, 0,0, 1,0,0,3,0));
        tbl.push_back(v(0,0,0,1,0, 0,0, 0,0,1,0,0));
        tbl.push_back(v(1,0,0,1,0, 0,0, 0,0,1,0,0));  // halt+step in HALT: no pulse
        tbl.push_back(v(1,1,1,0,0, 5,4, 1,0,0,1,0));  // step beats nstep and run
        tbl.push_back(v(0,0,0,0,0, 0,0, 0,0,1,0,0));
        tbl.push_back(v(0,1,1,0,0, 2,4, 1,0,0,2,2));  // nstep beats run
        tbl.push_back(v(0,0,0,0,0, 0,0, 0,0,0,2,1));
        tbl.push_back(v(0,0,0,0,0, 0,0, 1,0,0,2,1));
        tbl.push_back(v(0,0,0,0,0, 0,0, 0,0,1,0,0));
        tbl.push_back(v(0,0,0,1,1, 0,0, 0,1,0,4,0));  // srst beats halt
        tbl.push_back(v(1,0,0,0,0, 0,0, 0,1,0,4,0));  // step ignored in SRST
        tbl.push_back(v(0,0,0,0,0, 0,0, 0,1,0,4,0));
        tbl.push_back(v(0,0,0,0,0, 0,0, 0,1,0,4,0));
        tbl.push_back(v(0,0,0,0,0, 0,0, 0,0,1,0,0));  // 4 reset cycles then HALT

        rst = 1'b0; pc_clr = 1'b1;
        step_tick = 0; run_tick = 0; nstep_tick = 0; halt_tick = 0; srst_tick = 0;
        nstep_cnt = '0; run_div = '0; bp_en = 1'b0; bp_addr = 16'd3;
        repeat (2) @(negedge clk);
        chk("reset state_o", state_o, 0);
        chk("reset halted", halted, 1);
        chk("reset pc_en", pc_en, 0);
        chk("reset core_rst", core_rst, 0);
        chk("reset bp_hit", bp_hit, 0);
        chk("reset steps_left", steps_left, 0);
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step_tick  = tbl[i].st;
            run_tick   = tbl[i].rn;
            nstep_tick = tbl[i].ns;
            halt_tick  = tbl[i].ht;
            srst_tick  = tbl[i].sr;
            nstep_cnt  = tbl[i].cnt;
            run_div    = tbl[i].dv;
            @(negedge clk);
            chk($sformatf("row%0d pc_en", i), pc_en, tbl[i].pe);
            chk($sformatf("row%0d core_rst", i), core_rst, tbl[i].cr);
            chk($sformatf("row%0d halted", i), halted, tbl[i].hd);
            chk($sformatf("row%0d state_o", i), state_o, tbl[i].so);
            chk($sformatf("row%0d steps_left", i), steps_left, tbl[i].sl);
        end
        step_tick = 0; run_tick = 0; nstep_tick = 0; halt_tick = 0; srst_tick = 0;

        // halt_tick in the gap after the 2nd N-step pulse
        nstep_cnt = 16'd5; nstep_tick = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            go();
            if (pc_en) pulses++;
        end
        chk("nstep halt pulses before halt", pulses, 2);
        chk("nstep halt steps_left before", steps_left, 3);
        halt_tick = 1'b1;
        go();
        chk("nstep halt state_o", state_o, 0);
        chk("nstep halt steps_left", steps_left, 3);
        for (int i = 0; i < 4; i++) begin
            go();
            if (pc_en) pulses++;
        end
        chk("nstep halt no further pulses", pulses, 2);
        chk("nstep halt steps_left kept", steps_left, 3);

        // Breakpoint at PC 3 in RUN, then resume past it
        pc_clr = 1'b1;
        go();
        pc_clr = 1'b0;
        bp_en = 1'b1; bp_addr = 16'd3;
        run_div = 24'd4; run_tick = 1'b1;
        go();
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            if (halted) break;
            if (pc_en) pulses++;
            go();
        end
        chk("bp halted", halted, 1);
        chk("bp core_pc", core_pc, 3);
        chk("bp bp_hit", bp_hit, 1);
        chk("bp pulses", pulses, 3);
        go();
        chk("bp bp_hit sticky", bp_hit, 1);
        run_tick = 1'b1;
        go();
        chk("bp resume bp_hit cleared", bp_hit, 0);
        chk("bp resume state_o", state_o, 3);
        for (int i = 0; i < 100; i++) begin
            if (halted || core_pc == 16'd4) break;
            go();
        end
        chk("bp resume passes PC 3", core_pc, 4);
        chk("bp resume still running", halted, 0);
        go();

        // Asynchronous reset while running; steps_left still holds 3 from above
        rst = 1'b0;
        #1;
        chk("async rst state_o", state_o, 0);
        chk("async rst halted", halted, 1);
        chk("async rst pc_en", pc_en, 0);
        chk("async rst steps_left", steps_left, 0);
        chk("async rst bp_hit", bp_hit, 0);
        go();
        rst = 1'b1;
        bp_en = 1'b0;
        go();
        chk("after rst pc_en", pc_en, 0);
        chk("after rst state_o", state_o, 0);

        // Soft reset during N-step
        nstep_cnt = 16'd5; nstep_tick = 1'b1;
        go();
        go();
        chk("srst nstep entered", state_o, 2);
        srst_tick = 1'b1;
        go();
        chk("srst steps_left", steps_left, 0);
        n_rst = 0; n_pe = 0;
        for (int i = 0; i < 20; i++) begin
            if (core_rst !== 1'b1) break;
            n_rst++;
            if (pc_en) n_pe++;
            go();
        end
        chk("srst core_rst cycles", n_rst, 4);
        chk("srst pc_en during reset", n_pe, 0);
        chk("srst then HALT", state_o, 0);

        // Soft reset retriggered in its 2nd cycle
        srst_tick = 1'b1;
        go();
        n_rst = 0; n_pe = 0;
        for (int i = 0; i < 20; i++) begin
            if (core_rst !== 1'b1) break;
            n_rst++;
            if (pc_en) n_pe++;
            if (n_rst == 2) srst_tick = 1'b1;
            go();
        end
        chk("srst restart core_rst cycles", n_rst, 6);
        chk("srst restart pc_en", n_pe, 0);
        chk("srst restart halted", halted, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/micro_exec_ctl.md
Name: micro_exec_ctl

Overview:
Execution controller for the micro core on the debug board. It generates the core's PCenable pulses in four modes:
- halt
- single-step
- N-step
- free-run at a programmable rate

It halts on a PC breakpoint and issues a timed soft-reset pulse to the core. It sits between the debounced button ticks and the micro core, and replaces the direct button-to-PCenable connection.

Parameters:
PC_W, 16, width of core PC and breakpoint address
CNT_W, 16, width of N-step counter
DIV_W, 24, width of run-rate divider
RST_CYC, 4, soft-reset pulse length in clk cycles (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
step_tick  in  1  one-cycle request: execute one instruction
run_tick  in  1  one-cycle request: enter free-run
nstep_tick  in  1  one-cycle request: execute nstep_cnt instructions
halt_tick  in  1  one-cycle request: stop
srst_tick  in  1  one-cycle request: soft-reset core
nstep_cnt  in  CNT_W  step count, sampled on nstep_tick
run_div  in  DIV_W  cycles between pulses in RUN, sampled on run_tick
bp_en  in  1  breakpoint enable (level)
bp_addr  in  PC_W  breakpoint PC
core_pc  in  PC_W  current PC from core
pc_en  out  1  one-cycle PCenable pulse to core
core_rst  out  1  active-high soft reset to core
halted  out  1  1 in HALT state
bp_hit  out  1  sticky: halted by breakpoint
steps_left  out  CNT_W  remaining N-step count
state_o  out  3  encoded state, for monitor mux

Behaviour:
- Reset (rst=0, async) forces the following, all registered:
  - state=HALT, pc_en=0, core_rst=0, halted=1, bp_hit=0, steps_left=0
  - divider=0, rst counter=0
- States: HALT, STEP, NSTEP, RUN, SRST.
- Request priority when several ticks arrive in the same cycle: srst > halt > step > nstep > run.
- HALT:
  - step_tick -> STEP.
  - nstep_tick with nstep_cnt!=0 -> NSTEP, steps_left<=nstep_cnt. nstep_cnt==0 is ignored; stay in HALT.
  - run_tick -> RUN, latch max(run_div,1) into period register, divider<=0.
  - Any transition out of HALT clears bp_hit.
- STEP: pc_en=1 for exactly the one cycle spent in STEP, then -> HALT. Latency from step_tick to pc_en is 1 cycle.
- NSTEP:
  - Asserts pc_en every other cycle: on the first cycle, then gaps of 1. This lets core_pc update before the breakpoint compare.
  - Each pulse decrements steps_left.
  - On the pulse that takes steps_left from 1 to 0 -> HALT on the next cycle.
- RUN:
  - divider counts 0..period-1. pc_en=1 when divider==period-1, then divider wraps to 0.
  - period=1 gives pc_en every cycle.
- Breakpoint:
  - Check in NSTEP/RUN only: bp_en && core_pc==bp_addr, sampled in a cycle where pc_en=0.
  - A match -> HALT and sets bp_hit. No further pc_en is issued.
  - If the PC equals bp_addr when the mode is entered, the first pulse still issues, so execution can continue past the breakpoint.
  - STEP ignores breakpoints.
- halt_tick in any non-SRST state -> HALT next cycle. A pc_en pulse already being driven that cycle completes; no further pulses. steps_left is kept and shown on the output.
- SRST:
  - Entered from any state on srst_tick.
  - core_rst=1 for exactly RST_CYC cycles, pc_en=0, steps_left<=0. All other ticks are ignored.
  - Then -> HALT.
  - A srst_tick arriving during SRST restarts the count.
- halted is 1 only in HALT. state_o encoding: HALT=0, STEP=1, NSTEP=2, RUN=3, SRST=4.
- Counters never underflow: steps_left saturates at 0.
- Divider wrap compares against the latched period. A run_div change during RUN takes effect only on the next run_tick.

Decomposition:
- Shared package micro_dbg_pkg holds:
  - exec_state_t enum with the values above
  - the state_o width constant
  - the request-priority order
- One natural sub-module: rate_div, a loadable DIV_W period counter emitting a tick. It is reused for the RUN pacing.
- Debouncing stays outside this block; the existing debounce instances feed the *_tick inputs.

Test Plan:
- Reset mid-RUN (rst low for 1 cycle) -> state_o=0, halted=1, pc_en=0 immediately, all counters 0.
- HALT, step_tick -> exactly one pc_en, 1 cycle later, then halted=1. nstep_tick with nstep_cnt=0 -> no pc_en, stays HALT.
- nstep_cnt=5, nstep_tick -> 5 pc_en pulses spaced 2 cycles apart, steps_left 5..0, HALT after the last pulse. halt_tick after the 2nd pulse -> stops with steps_left=3.
- run_div=4 -> pc_en every 4th cycle. run_div=0 -> every cycle. halt_tick and step_tick in the same cycle -> HALT wins, no extra pulse.
- bp_en=1, bp_addr=0x0003, core model increments PC per pulse from 0, RUN -> halts with core_pc=3, bp_hit=1. A new run_tick clears bp_hit and passes PC 3.
- srst_tick during NSTEP -> core_rst high exactly RST_CYC=4 cycles, pc_en=0 throughout, steps_left=0, then HALT. Second srst_tick at cycle 2 -> core_rst total 6 cycles.
